// File: rtl/md_issue_pkg.sv
// Shared definitions for the HI/LO issue controller: op codes, latency defaults, state encoding.
package md_issue_pkg;

    localparam int unsigned W_DEF        = 32;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned OP_W         = 5;
    localparam int unsigned ST_W         = 1;

    typedef enum logic [OP_W-1:0] {
        HILO_NONE  = 5'd0,
        HILO_MULT  = 5'd1,
        HILO_MULTU = 5'd2,
        HILO_DIV   = 5'd3,
        HILO_DIVU  = 5'd4,
        HILO_MFHI  = 5'd5,
        HILO_MFLO  = 5'd6,
        HILO_MTHI  = 5'd7,
        HILO_MTLO  = 5'd8
    } hilo_op_e;

    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_WAIT = 1'b1;

    // Unlisted codes behave as HILO_NONE and are never held for issue.
    function automatic logic op_known(input logic [OP_W-1:0] op);
        return (op >= OP_W'(HILO_MULT)) && (op <= OP_W'(HILO_MTLO));
    endfunction

    function automatic logic op_is_mult(input logic [OP_W-1:0] op);
        return (op == OP_W'(HILO_MULT)) || (op == OP_W'(HILO_MULTU));
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return (op == OP_W'(HILO_DIV)) || (op == OP_W'(HILO_DIVU));
    endfunction

    function automatic logic op_is_mf(input logic [OP_W-1:0] op);
        return (op == OP_W'(HILO_MFHI)) || (op == OP_W'(HILO_MFLO));
    endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// Load/decrement countdown that saturates at zero; tracks how long the HI/LO unit stays occupied.
module md_latency_ctr #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_issue.sv
// Execute-stage issue controller for the HI/LO multiply-divide unit.
// Holds one request, issues it once the latency countdown is clear, and returns mf read data.
module md_issue
    import md_issue_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [W-1:0]    req_a,
    input  logic [W-1:0]    req_b,
    input  logic            flush,
    output logic [OP_W-1:0] md_op,
    output logic [W-1:0]    md_a,
    output logic [W-1:0]    md_b,
    input  logic            md_busy,
    input  logic [W-1:0]    md_out,
    output logic            rd_valid,
    output logic [W-1:0]    rd_data,
    output logic            idle,
    output logic            busy_err
);

    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            rd_valid_q, rd_valid_d;
    logic [W-1:0]    rd_data_q, rd_data_d;
    logic            busy_err_q, busy_err_d;
    logic            cnt_zero;
    logic            issue;
    logic            ld;
    logic [CW-1:0]   ld_val;

    md_latency_ctr #(
        .CW(CW)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .zero_o     (cnt_zero)
    );

    // Issue depends only on state, countdown and flush; md_busy never gates md_op.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        busy_err_d = busy_err_q;
        ld         = 1'b0;
        ld_val     = '0;
        issue      = (state_q == ST_WAIT) && cnt_zero && !flush;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && op_known(req_op)) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush || issue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            if (op_is_mult(op_q)) begin
                ld     = 1'b1;
                ld_val = CW'(MULT_LAT);
            end else if (op_is_div(op_q)) begin
                ld     = 1'b1;
                ld_val = CW'(DIV_LAT);
            end
            if (op_is_mf(op_q)) begin
                rd_valid_d = 1'b1;
                rd_data_d  = md_out;
            end
        end

        // Unit claims busy although nothing is outstanding or being issued.
        if (md_busy && cnt_zero && !issue) begin
            busy_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_W'(HILO_NONE);
            a_q        <= '0;
            b_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_err_q <= busy_err_d;
        end
    end

    assign md_op     = issue ? op_q : OP_W'(HILO_NONE);
    assign md_a      = issue ? a_q : '0;
    assign md_b      = issue ? b_q : '0;
    assign req_ready = (state_q == ST_IDLE);
    assign idle      = (state_q == ST_IDLE) && cnt_zero;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy_err  = busy_err_q;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: HI/LO unit stand-in, cycle-level reference model, directed and random traffic.
module tb_md_issue;
    import md_issue_pkg::*;

    localparam int unsigned W        = 32;
    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_op = 5'd0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         flush = 1'b0;
    logic [4:0]   md_op;
    logic [W-1:0] md_a;
    logic [W-1:0] md_b;
    logic         md_busy = 1'b0;
    logic [W-1:0] md_out;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         idle;
    logic         busy_err;

    int n_chk = 0;
    int n_err = 0;

    md_issue #(.W(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_busy(md_busy),
        .md_out(md_out), .rd_valid(rd_valid), .rd_data(rd_data),
        .idle(idle), .busy_err(busy_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one op on {HI,LO}.
    function automatic logic [63:0] apply_op(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        logic [63:0] r;
        longint sa, sb;
        int qi, ri;
        r  = {hi, lo};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'd1: r = 64'(sa * sb);
            5'd2: r = {32'd0, a} * {32'd0, b};
            5'd3: if (b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
                qi = $signed(a) / $signed(b);
                ri = $signed(a) % $signed(b);
                r  = {32'(ri), 32'(qi)};
            end
            5'd4: if (b != 0) r = {a % b, a / b};
            5'd7: r[63:32] = a;
            5'd8: r[31:0] = a;
            default: ;
        endcase
        return r;
    endfunction

    // HI/LO unit stand-in: read data is combinational on md_op.
    logic [W-1:0] u_hi = '0;
    logic [W-1:0] u_lo = '0;
    assign md_out = (md_op == 5'd5) ? u_hi : (md_op == 5'd6) ? u_lo : '0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            u_hi <= '0;
            u_lo <= '0;
        end else if (md_op != 5'd0) begin
            {u_hi, u_lo} <= apply_op(md_op, md_a, md_b, u_hi, u_lo);
        end
    end

    // Reference model: a pending slot plus the absolute cycle at which the unit is free again.
    logic         pend = 1'b0;
    logic [4:0]   p_op = 5'd0;
    logic [W-1:0] p_a = '0, p_b = '0;
    int           mcyc = 0;
    int           free_at = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, e_rdd = '0;
    logic         e_rdv = 1'b0, e_err = 1'b0;

    always @(posedge clk or posedge rst) begin : ref_model
        logic iss;
        if (rst) begin
            pend = 1'b0; p_op = 5'd0; p_a = '0; p_b = '0;
            mcyc = 0; free_at = 0; m_hi = '0; m_lo = '0;
            e_rdd = '0; e_rdv = 1'b0; e_err = 1'b0;
        end else begin
            iss   = pend && (mcyc >= free_at) && !flush;
            e_rdv = 1'b0;
            if (md_busy && (mcyc >= free_at) && !iss) e_err = 1'b1;
            if (iss) begin
                if (p_op == 5'd5) begin e_rdv = 1'b1; e_rdd = m_hi; end
                if (p_op == 5'd6) begin e_rdv = 1'b1; e_rdd = m_lo; end
                if (p_op == 5'd1 || p_op == 5'd2) free_at = mcyc + 1 + MULT_LAT;
                if (p_op == 5'd3 || p_op == 5'd4) free_at = mcyc + 1 + DIV_LAT;
                {m_hi, m_lo} = apply_op(p_op, p_a, p_b, m_hi, m_lo);
                pend = 1'b0;
            end else if (pend) begin
                if (flush) pend = 1'b0;
            end else if (req_valid && req_op >= 5'd1 && req_op <= 5'd8) begin
                pend = 1'b1; p_op = req_op; p_a = req_a; p_b = req_b;
            end
            mcyc++;
        end
    end

    // Per-cycle comparison against the model, plus issue/read bookkeeping for directed checks.
    int           ncyc = 0;
    int           iss_cyc[32];
    int           iss_cnt[32];
    int           rd_cnt = 0;

    always @(negedge clk) begin : compare
        logic e_iss;
        ncyc++;
        e_iss = pend && (mcyc >= free_at) && !flush;
        chk("md_op", 32'(md_op), e_iss ? 32'(p_op) : 32'd0);
        chk("md_a", md_a, e_iss ? p_a : 32'd0);
        chk("md_b", md_b, e_iss ? p_b : 32'd0);
        chk("req_ready", 32'(req_ready), 32'(!pend));
        chk("idle", 32'(idle), 32'(!pend && (mcyc >= free_at)));
        chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
        chk("rd_data", rd_data, e_rdd);
        chk("busy_err", 32'(busy_err), 32'(e_err));
        if (md_op !== 5'd0 && !$isunknown(md_op)) begin
            iss_cyc[md_op] = ncyc;
            iss_cnt[md_op]++;
        end
        if (rd_valid === 1'b1) rd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rd(input int prev);
        int n = 0;
        while (rd_cnt == prev && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) chk("rd_timeout", 32'(rd_cnt), 32'(prev + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int d0;
        int n;
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_md_op", 32'(md_op), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // mult 7 * -3, then mflo / mfhi
        send(5'd1, 32'd7, 32'hFFFF_FFFD);
        rc = rd_cnt;
        send(5'd6, 32'd0, 32'd0);
        wait_rd(rc);
        chk("mflo_data", rd_data, 32'hFFFF_FFEB);
        chk("mflo_gap", 32'(iss_cyc[6] - iss_cyc[1]), 32'd6);
        rc = rd_cnt;
        send(5'd5, 32'd0, 32'd0);
        wait_rd(rc);
        chk("mfhi_after_mult", rd_data, 32'hFFFF_FFFF);

        // divu 100 / 7, then mfhi / mflo
        send(5'd4, 32'd100, 32'd7);
        rc = rd_cnt;
        send(5'd5, 32'd0, 32'd0);
        wait_rd(rc);
        chk("divu_hi", rd_data, 32'd2);
        chk("divu_gap", 32'(iss_cyc[5] - iss_cyc[4]), 32'd11);
        rc = rd_cnt;
        send(5'd6, 32'd0, 32'd0);
        wait_rd(rc);
        chk("divu_lo", rd_data, 32'd14);

        // mthi then mfhi with no countdown in between
        send(5'd7, 32'h0000_1234, 32'd0);
        rc = rd_cnt;
        send(5'd5, 32'd0, 32'd0);
        wait_rd(rc);
        chk("mthi_rd", rd_data, 32'h0000_1234);
        chk("mthi_gap", 32'(iss_cyc[5] - iss_cyc[7]), 32'd2);
        chk("rd_pulse", 32'(rd_valid), 32'd0);

        // div queued behind a mult, flushed while the count is 3
        send(5'd1, 32'd3, 32'd4);
        d0 = iss_cnt[3];
        send(5'd3, 32'd50, 32'd5);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_ready", 32'(req_ready), 32'd1);
        chk("flush_not_idle", 32'(idle), 32'd0);
        tick(1);
        chk("flush_cnt_running", 32'(idle), 32'd0);
        tick(1);
        chk("flush_idle", 32'(idle), 32'd1);
        chk("flush_no_div", 32'(iss_cnt[3]), 32'(d0));

        // async reset four cycles into a divide
        send(5'd3, 32'd1000, 32'd3);
        tick(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_md_op", 32'(md_op), 32'd0);
        chk("arst_md_a", md_a, 32'd0);
        chk("arst_md_b", md_b, 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_busy_err", 32'(busy_err), 32'd0);
        tick(1);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            req_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 11);
            if (r <= 8) req_op = 5'(r);
            else if (r == 9) req_op = 5'($urandom_range(9, 31));
            else req_op = 5'($urandom_range(5, 6));
            req_a = $urandom;
            req_b = $urandom;
            if (req_b == 32'd0) req_b = 32'd1;
            flush = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        req_valid = 1'b0;
        flush = 1'b0;

        // spurious busy while nothing is outstanding
        n = 0;
        while (!idle && n < 100) begin
            tick(1);
            n++;
        end
        chk("pre_busy_idle", 32'(idle), 32'd1);
        md_busy = 1'b1;
        tick(1);
        md_busy = 1'b0;
        tick(1);
        chk("busy_err_set", 32'(busy_err), 32'd1);
        tick(5);
        chk("busy_err_sticky", 32'(busy_err), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("busy_err_rst", 32'(busy_err), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
